gpu_ucode_sequencer: RTL

//  Parametrised, writable microcode store plus program sequencer for the GPU scanline engine.

---
 rtl/gpu_ucode_sequencer_if.sv | 36 +++
 rtl/gpu_ucode_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/gpu_ucode_sequencer_if.sv
// Bundle of host-load, start/control, redirect-request and issue signals
// shared between the microcode sequencer and its host/datapath.
interface gpu_ucode_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int UOP_W  = 20
);
  logic              iLoadEn;
  logic [ADDR_W-1:0] iLoadAddr;
  logic [UOP_W-1:0]  iLoadData;
  logic              iStart;
  logic [ADDR_W-1:0] iStartAddr;
  logic              iStall;
  logic              iBranch;
  logic              iCall;
  logic              iReturn;
  logic              iHalt;
  logic [ADDR_W-1:0] iTarget;
  logic [UOP_W-1:0]  oUop;
  logic              oUopValid;
  logic [ADDR_W-1:0] oPC;
  logic              oError;

  // Host / datapath side: drives requests, consumes issued uops
  modport master (
    output iLoadEn, iLoadAddr, iLoadData, iStart, iStartAddr, iStall,
           iBranch, iCall, iReturn, iHalt, iTarget,
    input  oUop, oUopValid, oPC, oError
  );

  // Sequencer side
  modport slave (
    input  iLoadEn, iLoadAddr, iLoadData, iStart, iStartAddr, iStall,
           iBranch, iCall, iReturn, iHalt, iTarget,
    output oUop, oUopValid, oPC, oError
  );
endinterface

// File: rtl/gpu_ucode_sequencer.sv
// Writable microcode store plus program sequencer for the scanline engine.
// One uop is issued per cycle from a synchronous-read store; the datapath
// redirects flow via branch/call/return requests that refer to the uop
// currently on oUop. A bounded call stack faults into a sticky ERROR state.
module gpu_ucode_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int UOP_W       = 20,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  iClock,
  input  logic                  iReset,
  gpu_ucode_sequencer_if.slave  bus
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {st_idle, st_run, st_error} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] opc_reg;
  logic [UOP_W-1:0]  uop_reg;
  logic              valid_reg, valid_next;
  logic              error_reg, error_next;
  logic [SP_W-1:0]   sp_reg, sp_next;

  logic [ADDR_W-1:0] ra;
  logic              fetch;
  logic              push;
  logic              fault;
  logic              store_we;
  logic [ADDR_W-1:0] ret_addr;
  logic [ADDR_W-1:0] ret_push;

  logic [UOP_W-1:0]  store [DEPTH];
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  // The return address pushed by a call is the uop after the one issuing it
  assign ret_push = opc_reg + 1'b1;

  // One register per call-stack entry; only the entry at sp is written on a push
  genvar gi;
  generate
    for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
      logic [ADDR_W-1:0] entry_reg;

      // Capture the return address when this slot is the top of stack
      always_ff @(posedge iClock) begin
        if (push && (sp_reg == SP_W'(gi))) begin
          entry_reg <= ret_push;
        end
      end

      assign stack_q[gi] = entry_reg;
    end
  endgenerate

  // Top-of-stack read mux (entry sp-1)
  always_comb begin
    ret_addr = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp_reg == SP_W'(i + 1)) begin
        ret_addr = stack_q[i];
      end
    end
  end

  // Next-state, read-address selection and redirect priority
  always_comb begin
    state_next = state_reg;
    ra         = pc_reg;
    fetch      = 1'b0;
    push       = 1'b0;
    fault      = 1'b0;
    store_we   = 1'b0;
    sp_next    = sp_reg;
    valid_next = valid_reg;
    error_next = error_reg;
    case (state_reg)
      st_idle, st_error: begin
        if (bus.iStart) begin
          ra         = bus.iStartAddr;
          fetch      = 1'b1;
          sp_next    = '0;
          error_next = 1'b0;
          state_next = st_run;
        end else if ((state_reg == st_idle) && bus.iLoadEn) begin
          store_we = 1'b1;
        end
      end
      st_run: begin
        if (!bus.iStall) begin
          if (!valid_reg) begin
            fetch = 1'b1;
          end else if (bus.iHalt) begin
            state_next = st_idle;
            valid_next = 1'b0;
          end else if (bus.iReturn) begin
            if (sp_reg == '0) begin
              fault = 1'b1;
            end else begin
              ra      = ret_addr;
              sp_next = sp_reg - 1'b1;
              fetch   = 1'b1;
            end
          end else if (bus.iCall) begin
            if (sp_reg == SP_W'(STACK_DEPTH)) begin
              fault = 1'b1;
            end else begin
              push    = 1'b1;
              sp_next = sp_reg + 1'b1;
              ra      = bus.iTarget;
              fetch   = 1'b1;
            end
          end else if (bus.iBranch) begin
            ra    = bus.iTarget;
            fetch = 1'b1;
          end else begin
            fetch = 1'b1;
          end
        end
      end
      default: begin
        state_next = st_idle;
      end
    endcase
    if (fault) begin
      state_next = st_error;
      valid_next = 1'b0;
      error_next = 1'b1;
    end
    if (fetch) begin
      valid_next = 1'b1;
    end
  end

  // Sequencer state registers; reset aborts immediately
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_reg <= st_idle;
      pc_reg    <= '0;
      opc_reg   <= '0;
      sp_reg    <= '0;
      valid_reg <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      sp_reg    <= sp_next;
      valid_reg <= valid_next;
      error_reg <= error_next;
      if (fetch) begin
        pc_reg  <= ra + 1'b1;
        opc_reg <= ra;
      end
    end
  end

  // Registered store read; the output register clears on reset, the array does not
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      uop_reg <= '0;
    end else if (fetch) begin
      uop_reg <= store[ra];
    end
  end

  // Host writes into the store (only ever enabled while idle)
  always_ff @(posedge iClock) begin
    if (store_we) begin
      store[bus.iLoadAddr] <= bus.iLoadData;
    end
  end

  assign bus.oUop      = uop_reg;
  assign bus.oUopValid = valid_reg;
  assign bus.oPC       = opc_reg;
  assign bus.oError    = error_reg;

endmodule
